oled_spi_tx: RTL and testbench

Byte-oriented 4-wire SPI transmitter for the SSD1306-class OLED. It sits directly downstream of the CPU's parallel output port. The CPU pushes 12-bit words with `wr_en`, and the block queues them and serialises them onto SCL/SDA/DC, which replaces bit-banging of P[2]/P[6]/P[8]. It also generates the panel power-on reset pulse on RES (P[9]) and returns status the CPU can read back into register A.

---
 rtl/oled_spi_tx.sv | 213 +++++++++++++++++++++
 tb/tb_oled_spi_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_tx.sv
// ---------------------------------------------------------------------------
// oled_spi_tx : queued 4-wire SPI (mode 0) byte transmitter for SSD1306 OLEDs.
// Define OLED_RES_SEQ_EN to build in the power-on RES pulse.  Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module oled_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int RES_CYCLES = 1024
) (
  input  logic        clk_pll,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [11:0] wr_data,
  output logic [11:0] status,
  output logic        oled_scl,
  output logic        oled_sda,
  output logic        oled_dc,
  output logic        oled_res
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_MAX  = DIVW'(CLK_DIV - 1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);

  if (CLK_DIV < 1) begin : g_chk_div
    $error("CLK_DIV must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (RES_CYCLES < 1) begin : g_chk_res
    $error("RES_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
`ifdef OLED_RES_SEQ_EN
    , ST_RESET = 2'd3
`endif
  } state_e;

`ifdef OLED_RES_SEQ_EN
  localparam state_e ST_START = ST_RESET;
`else
  localparam state_e ST_START = ST_IDLE;
`endif

  state_e          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            scl_q, scl_d, sda_q, sda_d, dc_q, dc_d;
  logic            ovf_q;

  logic [8:0]      fifo_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic            w_full, w_empty, w_push, w_pop, w_busy, w_res_done;
  logic [8:0]      w_head;
  logic            unused_wr_hi;

  assign unused_wr_hi = ^wr_data[11:9];

  // Full/empty come from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_full  = (cnt_q == FULL_CNT);
  assign w_empty = (cnt_q == '0);
  assign w_push  = wr_en && !w_full;
  assign w_pop   = (state_q == ST_LOAD);
  assign w_head  = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_pll) begin
    if (w_push) fifo_q[wr_ptr_q] <= wr_data[8:0];
  end

  always_ff @(posedge clk_pll or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && w_full) ovf_q <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef OLED_RES_SEQ_EN
  localparam int RCW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
  localparam logic [RCW-1:0] RES_MAX = RCW'(RES_CYCLES - 1);
  logic [RCW-1:0] res_cnt_q, res_cnt_d;
  logic           res_q, res_d, res_done_q, res_done_d;

  always_ff @(posedge clk_pll or negedge rst) begin
    if (!rst) begin
      res_cnt_q  <= '0;
      res_q      <= 1'b0;
      res_done_q <= 1'b0;
    end else begin
      res_cnt_q  <= res_cnt_d;
      res_q      <= res_d;
      res_done_q <= res_done_d;
    end
  end

  assign oled_res   = res_q;
  assign w_res_done = res_done_q;
`else
  assign oled_res   = 1'b1;
  assign w_res_done = 1'b1;
`endif

  always_ff @(posedge clk_pll or negedge rst) begin
    if (!rst) begin
      state_q <= ST_START;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      dc_q    <= dc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    dc_d    = dc_q;
`ifdef OLED_RES_SEQ_EN
    res_cnt_d  = res_cnt_q;
    res_d      = res_q;
    res_done_d = res_done_q;
`endif
    case (state_q)
`ifdef OLED_RES_SEQ_EN
      ST_RESET: begin
        if (res_cnt_q == RES_MAX) begin
          res_d      = 1'b1;
          res_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          res_cnt_d = res_cnt_q + RCW'(1);
        end
      end
`endif
      ST_IDLE: begin
        if (!w_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = w_head[7:0];
        dc_d    = w_head[8];
        sda_d   = w_head[7];
        bit_d   = '0;
        div_d   = '0;
        scl_d   = 1'b0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          scl_d = ~scl_q;
          // Falling edge: advance to the next bit, or leave after the 8th.
          if (scl_q) begin
            if (bit_q == 3'd7) begin
              bit_d   = '0;
              state_d = w_empty ? ST_IDLE : ST_LOAD;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
              sda_d   = shift_q[6];
            end
          end
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      default: state_d = ST_START;
    endcase
  end

  assign w_busy   = !w_empty || (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign status   = {8'b0, ovf_q, w_res_done, w_full, w_busy};
  assign oled_scl = scl_q;
  assign oled_sda = sda_q;
  assign oled_dc  = dc_q;

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_tx.sv
// ---------------------------------------------------------------------------
// tb_oled_spi_tx : scoreboard bench; SPI bytes decoded on SCL rises and
// compared against the queue of bytes expected from the directed pushes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_oled_spi_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int RES_CYCLES = 16;
  localparam int BYTE_CYC   = 16 * CLK_DIV + 1;
`ifdef OLED_RES_SEQ_EN
  localparam logic [11:0] ST_RST = 12'h000;
  localparam int          ACC    = 8;
`else
  localparam logic [11:0] ST_RST = 12'h004;
  localparam int          ACC    = 9;
`endif

  logic        clk_pll = 1'b0;
  logic        rst     = 1'b1;
  logic        wr_en   = 1'b0;
  logic [11:0] wr_data = '0;
  logic [11:0] status;
  logic        oled_scl, oled_sda, oled_dc, oled_res;

  oled_spi_tx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .RES_CYCLES(RES_CYCLES)
  ) dut (
    .clk_pll (clk_pll),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .status  (status),
    .oled_scl(oled_scl),
    .oled_sda(oled_sda),
    .oled_dc (oled_dc),
    .oled_res(oled_res)
  );

  always #5 clk_pll = ~clk_pll;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  exp_q[$];
  logic        mon_prev = 1'b0;
  int          mon_nb   = 0;
  logic [7:0]  mon_sh   = '0;
  logic        mon_dc   = 1'b0;
  logic [8:0]  mon_exp;
  logic [11:0] d;
  int          highs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pll);
    #1;
  endtask

  task automatic push(input logic [11:0] v);
    @(negedge clk_pll);
    wr_en   = 1'b1;
    wr_data = v;
    @(posedge clk_pll);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int k = 0;
    while ((status[0] || !status[2]) && k < budget) begin
      tick(1);
      k++;
    end
    check(name, {status[2], status[0]}, 2'b10);
  endtask

  // Monitor: rebuild each byte from SDA at SCL rises and pop the scoreboard.
  initial begin
    forever begin
      @(negedge clk_pll);
      if (!rst) begin
        mon_nb   = 0;
        mon_prev = 1'b0;
      end else begin
        if (oled_scl && !mon_prev) begin
          if (mon_nb == 0) mon_dc = oled_dc;
          mon_sh = {mon_sh[6:0], oled_sda};
          mon_nb++;
          if (mon_nb == 8) begin
            mon_nb = 0;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected byte: got 0x%0h, expected none", {mon_dc, mon_sh});
            end else begin
              mon_exp = exp_q.pop_front();
              check("rx byte", {23'b0, mon_dc, mon_sh}, {23'b0, mon_exp});
            end
          end
        end
        mon_prev = oled_scl;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #1 rst = 1'b0;
    #2;
    check("reset scl", oled_scl, 0);
    check("reset sda", oled_sda, 0);
    check("reset dc", oled_dc, 0);
    check("reset status", status, ST_RST);
`ifdef OLED_RES_SEQ_EN
    check("reset res", oled_res, 0);
`else
    check("reset res", oled_res, 1);
`endif

    // Release rst with a push queued in the same cycle
    @(negedge clk_pll);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 12'h1AE;
    exp_q.push_back(9'h1AE);
    @(posedge clk_pll);
    #1;
    wr_en = 1'b0;
    tick(RES_CYCLES - 2);
`ifdef OLED_RES_SEQ_EN
    check("res low before end", oled_res, 0);
    check("res_done low", status[2], 0);
    check("no scl during reset", oled_scl, 0);
    tick(1);
    check("res high", oled_res, 1);
    check("res_done high", status[2], 1);
`else
    check("res constant", oled_res, 1);
    check("res_done constant", status[2], 1);
`endif
    wait_ready("first byte done", 200);

    // Single byte timing
    exp_q.push_back(9'h0AE);
    push(12'h0AE);
    tick(1);
    check("busy after push", status[0], 1);
    tick(1);
    check("load dc", oled_dc, 0);
    check("load sda msb", oled_sda, 1);
    check("scl low after load", oled_scl, 0);
    tick(CLK_DIV - 1);
    check("scl low before first rise", oled_scl, 0);
    tick(1);
    check("first scl rise", oled_scl, 1);
    tick(CLK_DIV);
    check("first scl fall", oled_scl, 0);
    check("second bit", oled_sda, 0);
    tick(16 * CLK_DIV - 2 * CLK_DIV - 1);
    check("scl high before last fall", oled_scl, 1);
    check("busy during last bit", status[0], 1);
    tick(1);
    check("last scl fall", oled_scl, 0);
    check("busy clears", status[0], 0);
    check("sda holds last bit", oled_sda, 0);

    // DC per byte, one LOAD cycle between bytes
    exp_q.push_back(9'h1FF);
    exp_q.push_back(9'h000);
    push(12'h1FF);
    push(12'h000);
    tick(1);
    check("dc first byte", oled_dc, 1);
    check("sda first byte", oled_sda, 1);
    tick(BYTE_CYC - 1);
    check("dc held in load", oled_dc, 1);
    check("busy in load", status[0], 1);
    tick(1);
    check("dc second byte", oled_dc, 0);
    check("sda second byte", oled_sda, 0);
    wait_ready("dc bytes done", 300);

    // Full / overflow
`ifdef OLED_RES_SEQ_EN
    @(negedge clk_pll);
    rst = 1'b0;
    @(negedge clk_pll);
    rst = 1'b1;
`endif
    for (int i = 0; i < 10; i++) begin
      d = {3'b101, i[0], 8'(8'h30 + i)};
      if (i < ACC) exp_q.push_back(d[8:0]);
      push(d);
      if (i + 1 == ACC - 1) check("not full yet", status[1], 0);
      if (i + 1 == ACC) begin
        check("full", status[1], 1);
        check("no overflow yet", status[3], 0);
      end
      if (i + 1 == ACC + 1) check("overflow set", status[3], 1);
    end
    wait_ready("burst drained", 12 * BYTE_CYC + 3 * RES_CYCLES);
    check("overflow sticky", status[3], 1);
    check("not full after drain", status[1], 0);

    // Reset mid-byte
    push(12'h0AE);
    push(12'h155);
    tick(27);
    @(negedge clk_pll);
    rst = 1'b0;
    #1;
    check("abort scl", oled_scl, 0);
    check("abort sda", oled_sda, 0);
    check("abort status", status, ST_RST);
    @(negedge clk_pll);
    rst   = 1'b1;
    highs = 0;
    for (int c = 0; c < RES_CYCLES + 2 * BYTE_CYC; c++) begin
      tick(1);
      if (oled_scl) highs++;
    end
    check("no scl after abort", highs, 0);
    check("idle after abort", {status[3], status[1], status[0]}, 3'b000);

    // New push after abort still transmits
    exp_q.push_back(9'h0C3);
    push(12'h0C3);
    wait_ready("post-abort byte done", 200);
    tick(2);
    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
